alu_result_checker: RTL and testbench



---
 rtl/alu_result_checker.sv | 166 ++++++++++++++++
 tb/tb_alu_result_checker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// ALU scoreboard: checks observed S against a reference model, counts pass/fail/illegal, captures the first mismatch.
// Latency 2 (S1 register, S2 compare). in_ready drops in DRAIN/HALT and in the cycle a halting mismatch sits in S2.
module alu_result_checker #(
  parameter int W           = 32,
  parameter int CNT_W       = 16,
  parameter int HALT_ON_ERR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [3:0]       in_op,
  input  logic [W-1:0]     in_s,
  input  logic             clear,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] illegal_count,
  output logic             err_valid,
  output logic [3:0]       err_op,
  output logic [W-1:0]     err_a,
  output logic [W-1:0]     err_b,
  output logic [W-1:0]     err_s,
  output logic [W-1:0]     err_exp,
  output logic             halted
);

  localparam bit HALT_EN = (HALT_ON_ERR != 0);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
  state_t state;

  logic         s1_vld;
  logic [W-1:0] s1_a, s1_b, s1_s;
  logic [3:0]   s1_op;
  logic         s2_vld, s2_legal, s2_mis;
  logic [W-1:0] s2_a, s2_b, s2_s, s2_exp;
  logic [3:0]   s2_op;

  logic [W-1:0] s1_exp;
  logic         s1_legal;
  logic [4:0]   sh;

  assign sh = s1_b[4:0];

  always_comb begin
    s1_exp   = '0;
    s1_legal = 1'b1;
    case (s1_op)
      4'b0000: s1_exp = s1_a + s1_b;
      4'b1000: s1_exp = s1_a - s1_b;
      4'b0001: s1_exp = s1_a << sh;
      4'b0010: s1_exp = {{(W-1){1'b0}}, $signed(s1_a) < $signed(s1_b)};
      4'b0011: s1_exp = {{(W-1){1'b0}}, s1_a < s1_b};
      4'b0100: s1_exp = s1_a ^ s1_b;
      4'b0101: s1_exp = s1_a >> sh;
      4'b1101: s1_exp = $signed(s1_a) >>> sh;
      4'b0110: s1_exp = s1_a | s1_b;
      4'b0111: s1_exp = s1_a & s1_b;
      default: s1_legal = 1'b0;
    endcase
  end

  logic halt_now, accept, pass_ev, fail_ev, ill_ev;

  // A halting mismatch in S2 blocks intake one cycle early so at most one more transaction follows it.
  assign halt_now = HALT_EN && s2_vld && s2_legal && s2_mis;
  assign in_ready = !rst && (state == RUN) && !halt_now;
  assign accept   = in_valid && in_ready;
  assign pass_ev  = s2_vld && s2_legal && !s2_mis;
  assign fail_ev  = s2_vld && s2_legal && s2_mis;
  assign ill_ev   = s2_vld && !s2_legal;
  assign halted   = (state == HALT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != {CNT_W{1'b1}})) ? c + 1'b1 : c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      s1_vld        <= 1'b0;
      s1_a          <= '0;
      s1_b          <= '0;
      s1_s          <= '0;
      s1_op         <= '0;
      s2_vld        <= 1'b0;
      s2_legal      <= 1'b0;
      s2_mis        <= 1'b0;
      s2_a          <= '0;
      s2_b          <= '0;
      s2_s          <= '0;
      s2_exp        <= '0;
      s2_op         <= '0;
      pass_count    <= '0;
      fail_count    <= '0;
      illegal_count <= '0;
      err_valid     <= 1'b0;
      err_op        <= '0;
      err_a         <= '0;
      err_b         <= '0;
      err_s         <= '0;
      err_exp       <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_s  <= in_s;
        s1_op <= in_op;
      end

      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_legal <= s1_legal;
        s2_mis   <= (s1_exp != s1_s);
        s2_a     <= s1_a;
        s2_b     <= s1_b;
        s2_s     <= s1_s;
        s2_exp   <= s1_exp;
        s2_op    <= s1_op;
      end

      pass_count    <= sat_inc(pass_count, pass_ev);
      fail_count    <= sat_inc(fail_count, fail_ev);
      illegal_count <= sat_inc(illegal_count, ill_ev);

      if (fail_ev && !err_valid) begin
        err_valid <= 1'b1;
        err_op    <= s2_op;
        err_a     <= s2_a;
        err_b     <= s2_b;
        err_s     <= s2_s;
        err_exp   <= s2_exp;
      end

      case (state)
        RUN: begin
          if (clear)         state <= DRAIN;
          else if (halt_now) state <= HALT;
        end
        HALT: begin
          if (clear) state <= DRAIN;
        end
        DRAIN: begin
          // Zeroing waits for an empty pipeline, so no counter update can race with it.
          if (!s1_vld && !s2_vld) begin
            pass_count    <= '0;
            fail_count    <= '0;
            illegal_count <= '0;
            err_valid     <= 1'b0;
            err_op        <= '0;
            err_a         <= '0;
            err_b         <= '0;
            err_s         <= '0;
            err_exp       <= '0;
            state         <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench: accepted transactions queue their model result; a negedge monitor pops and compares counters/capture.
module tb_alu_result_checker;
  localparam int W = 32;
  localparam int CNT_W = 4;
  localparam int SAT = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0, in_b = '0, in_s = '0;
  logic [3:0]       in_op = '0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] pass_count, fail_count, illegal_count;
  logic             err_valid, halted;
  logic [3:0]       err_op;
  logic [W-1:0]     err_a, err_b, err_s, err_exp;

  alu_result_checker #(.W(W), .CNT_W(CNT_W), .HALT_ON_ERR(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_s(in_s), .clear(clear),
    .pass_count(pass_count), .fail_count(fail_count), .illegal_count(illegal_count),
    .err_valid(err_valid), .err_op(err_op), .err_a(err_a), .err_b(err_b),
    .err_s(err_s), .err_exp(err_exp), .halted(halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        legal;
    logic [3:0]  op;
    logic [31:0] a, b, s, exp;
  } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  bit mon_en = 1'b1;
  int m_pass = 0, m_fail = 0, m_ill = 0;
  bit m_ev = 1'b0;
  bit m_failed = 1'b0;
  logic [3:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_s = '0, m_exp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: straight from the operation table, using unsigned arithmetic and bias tricks.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [31:0] ones;
    sh = b % 32;
    ones = 32'hFFFF_FFFF;
    case (op)
      4'b0000: return {1'b1, a + b};
      4'b1000: return {1'b1, a - b};
      4'b0001: return {1'b1, a << sh};
      4'b0010: return {1'b1, 31'd0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)};
      4'b0011: return {1'b1, 31'd0, a < b};
      4'b0100: return {1'b1, a ^ b};
      4'b0101: return {1'b1, a >> sh};
      4'b1101: return {1'b1, (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0)};
      4'b0110: return {1'b1, a | b};
      4'b0111: return {1'b1, a & b};
      default: return 33'h0;
    endcase
  endfunction

  function automatic int sat(input int c);
    return (c < SAT) ? c + 1 : c;
  endfunction

  exp_t t;
  bit popped;
  always @(negedge clk) begin
    popped = 1'b0;
    while (mon_en && q.size() > 0 && q[0].due <= cyc) begin
      t = q.pop_front();
      popped = 1'b1;
      if (!t.legal) m_ill = sat(m_ill);
      else if (t.exp == t.s) m_pass = sat(m_pass);
      else begin
        m_fail = sat(m_fail);
        m_failed = 1'b1;
        if (!m_ev) begin
          m_ev = 1'b1; m_op = t.op; m_a = t.a; m_b = t.b; m_s = t.s; m_exp = t.exp;
        end
      end
    end
    if (popped) begin
      chk("pass_count", 32'(pass_count), m_pass);
      chk("fail_count", 32'(fail_count), m_fail);
      chk("illegal_count", 32'(illegal_count), m_ill);
      chk("err_valid", 32'(err_valid), 32'(m_ev));
      if (m_ev) begin
        chk("err_op", 32'(err_op), 32'(m_op));
        chk("err_a", err_a, m_a);
        chk("err_b", err_b, m_b);
        chk("err_s", err_s, m_s);
        chk("err_exp", err_exp, m_exp);
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic drive_one(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           input logic [31:0] s, output bit acc);
    logic [32:0] r;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_s = s;
    @(negedge clk);
    acc = in_ready;
    if (acc) begin
      r = ref_alu(op, a, b);
      q.push_back('{cyc + 3, r[32], op, a, b, s, r[31:0]});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    chk("pipeline_drained", q.size(), 0);
  endtask

  task automatic zero_model();
    m_pass = 0; m_fail = 0; m_ill = 0; m_ev = 1'b0; m_failed = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pass"}, 32'(pass_count), 0);
    chk({tag, "_fail"}, 32'(fail_count), 0);
    chk({tag, "_illegal"}, 32'(illegal_count), 0);
    chk({tag, "_err_valid"}, 32'(err_valid), 0);
    chk({tag, "_err_exp"}, err_exp, 0);
    chk({tag, "_halted"}, 32'(halted), 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic finish_clear();
    int n;
    n = 0;
    chk("drain_ready_low", 32'(in_ready), 0);
    while (!in_ready && n < 8) begin idle(1); n++; end
    chk("drain_edges_le3", 32'(n <= 3), 1);
    chk("drain_q_empty", q.size(), 0);
    zero_model();
    chk_zero("after_clear");
    chk("after_clear_ready", 32'(in_ready), 1);
  endtask

  bit acc;
  logic [32:0] r;
  logic [31:0] ra, rb, rs;
  logic [3:0]  rop;

  initial begin
    @(negedge clk);
    chk("reset_ready_low", 32'(in_ready), 0);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("reset_ready_high", 32'(in_ready), 1);
    idle(1);

    drive_one(32'd5, 32'd3, 4'b0000, 32'd8, acc);
    wait_idle();
    chk("add_pass", 32'(pass_count), 1);
    chk("add_err_valid", 32'(err_valid), 0);

    drive_one(-32'sd5, 32'd3, 4'b0010, 32'd1, acc);
    drive_one(-32'sd8, 32'd2, 4'b1101, 32'hFFFF_FFFE, acc);
    drive_one(-32'sd8, 32'd2, 4'b0101, 32'h3FFF_FFFE, acc);
    wait_idle();
    chk("signed_shift_pass", 32'(pass_count), 4);

    drive_one(32'd7, 32'd9, 4'b1001, 32'd0, acc);
    wait_idle();
    chk("illegal_count", 32'(illegal_count), 1);
    chk("illegal_no_fail", 32'(fail_count), 0);
    chk("illegal_err_valid", 32'(err_valid), 0);

    drive_one(32'd8, 32'd3, 4'b1000, 32'd4, acc);
    drive_one(32'd3, 32'd1, 4'b0111, 32'd1, acc);
    chk("btb_after_mismatch_accepted", 32'(acc), 1);
    drive_one(32'd1, 32'd1, 4'b0000, 32'd2, acc);
    chk("third_blocked", 32'(acc), 0);
    wait_idle();
    chk("halt_fail_count", 32'(fail_count), 1);
    chk("halt_err_exp", err_exp, 5);
    chk("halt_err_s", err_s, 4);
    chk("halt_pass_count", 32'(pass_count), 5);
    chk("halted", 32'(halted), 1);
    chk("halt_ready_low", 32'(in_ready), 0);

    pulse_clear();
    finish_clear();

    drive_one(32'd8, 32'd3, 4'b1000, 32'd4, acc);
    idle(1);
    pulse_clear();
    chk("clear_mis_counted", 32'(fail_count), 1);
    finish_clear();

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) idle(1);
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rop = 4'($urandom_range(0, 15));
      r = ref_alu(rop, ra, rb);
      rs = ($urandom_range(0, 24) == 0) ? r[31:0] ^ (32'd1 << $urandom_range(0, 31)) : r[31:0];
      drive_one(ra, rb, rop, rs, acc);
      if (!acc) begin
        wait_idle();
        chk("rand_halted", 32'(halted), 32'(m_failed));
        pulse_clear();
        finish_clear();
      end
    end
    wait_idle();
    if (halted || fail_count != 0 || illegal_count != 0 || pass_count != 0) begin
      pulse_clear();
      finish_clear();
    end

    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom;
      drive_one(ra, rb, 4'b0000, ra + rb, acc);
    end
    wait_idle();
    chk("sat_pass_count", 32'(pass_count), SAT);

    drive_one(32'd1, 32'd2, 4'b0100, 32'd0, acc);
    drive_one(32'd1, 32'd2, 4'b1111, 32'd0, acc);
    mon_en = 1'b0;
    q.delete();
    rst = 1'b1;
    idle(1);
    chk("midrst_ready_low", 32'(in_ready), 0);
    chk_zero("midrst");
    rst = 1'b0;
    zero_model();
    mon_en = 1'b1;
    #1;
    chk("midrst_ready_high", 32'(in_ready), 1);
    idle(4);
    chk_zero("midrst_flushed");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
